// File: rtl/return_addr_stack.sv
// Return-address stack: calls push the link address, returns pop a registered
// predicted target one cycle later. The circular buffer overwrites its oldest entry when full.
module return_addr_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             isCall,
  input  logic [XLEN-1:0]  linkAddr,
  input  logic             isRet,
  input  logic             flush,
  output logic [XLEN-1:0]  predPC,
  output logic             predValid,
  output logic             stackEmpty,
  output logic             stackFull,
  output logic [PTR_W:0]   count,
  output logic [7:0]       overflowCnt
);
  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] TOS_RST = PTR_W'(DEPTH-1);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] tos, tos_inc, tos_dec;
  logic [PTR_W:0]   cnt;
  logic             push, pop, swap, nonempty;

  // flush wins over any same-cycle call/return
  assign push     = isCall & ~isRet & ~flush;
  assign pop      = ~isCall & isRet & ~flush;
  assign swap     = isCall & isRet & ~flush;
  assign nonempty = (cnt != '0);
  assign tos_inc  = tos + PTR_W'(1);
  assign tos_dec  = tos - PTR_W'(1);

  assign count      = cnt;
  assign stackEmpty = (cnt == '0);
  assign stackFull  = (cnt == FULL);

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push)      mem[tos_inc] <= linkAddr;
    else if (swap) mem[tos]     <= linkAddr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos         <= TOS_RST;
      cnt         <= '0;
      predPC      <= '0;
      predValid   <= 1'b0;
      overflowCnt <= '0;
    end else begin
      predValid <= 1'b0;
      if (flush) begin
        cnt <= '0;
        tos <= TOS_RST;
      end else if (push) begin
        tos <= tos_inc;
        if (cnt != FULL)              cnt         <= cnt + 1'b1;
        else if (overflowCnt != 8'hFF) overflowCnt <= overflowCnt + 1'b1;
      end else if (pop) begin
        predValid <= nonempty;
        if (nonempty) begin
          predPC <= mem[tos];
          tos    <= tos_dec;
          cnt    <= cnt - 1'b1;
        end
      end else if (swap) begin
        // top replaced in place; an empty stack gains the new entry
        predValid <= nonempty;
        if (nonempty) predPC <= mem[tos];
        else          cnt    <= (PTR_W+1)'(1);
      end
    end
  end
endmodule
